// File: rtl/squarer_rr_scheduler.sv
// Round-robin scheduler sharing one 4-bit squarer datapath among NREQ requesters.
// Optional datapath self-check enabled by defining SQ_SELFCHECK_EN.
module squarer_rr_scheduler #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 1,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [3:0]        sq_a,
    input  logic [7:0]        sq_y,
    input  logic [31:0]       sq_garbage,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy,
    output logic [15:0]       op_count,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0]     CNT_LOAD = 4'(SETTLE - 1);
    localparam logic [IDW-1:0] LG_RST   = IDW'(NREQ - 1);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    logic [1:0]     state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     a_q, a_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] lg_q, lg_d;
    logic [7:0]     data_q, data_d;
    logic [15:0]    opcnt_q, opcnt_d;
    logic           err_d;

    logic [IDW-1:0] cand;
    logic [IDW-1:0] win;
    logic           any;
    logic           grant;
    logic           capture;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        cand = lg_q;
        win  = '0;
        any  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
            if (!any && req_valid[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
    end

    assign grant     = (state_q == S_IDLE) && any && !rst;
    assign capture   = (state_q == S_EXEC) && (cnt_q == 4'd0);
    assign req_ready = grant ? (NREQ'(1) << win) : '0;
    assign sq_a      = (state_q == S_EXEC) ? a_q : 4'h0;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != S_IDLE);
    assign op_count  = opcnt_q;

`ifdef SQ_SELFCHECK_EN
    logic       err_q;
    logic [7:0] ref_sq;
    logic       chk_bad;
    logic       unused_garbage;

    assign ref_sq         = {4'h0, a_q} * {4'h0, a_q};
    assign chk_bad        = (sq_y != ref_sq) || (|sq_garbage[31:21]);
    assign unused_garbage = ^sq_garbage[20:0];
    assign err_d          = err_q | (capture & chk_bad);
    assign err            = err_q;

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`else
    logic unused_garbage;

    assign unused_garbage = ^sq_garbage;
    assign err_d          = 1'b0;
    assign err            = err_d;
`endif

    // Next-state logic for the grant / settle / respond sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        id_d    = id_q;
        lg_d    = lg_q;
        data_d  = data_q;
        opcnt_d = opcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    a_d     = req_data[{win, 2'b00} +: 4];
                    id_d    = win;
                    lg_d    = win;
                    cnt_d   = CNT_LOAD;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (capture) begin
                    data_d  = sq_y;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    opcnt_d = opcnt_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 4'h0;
            id_q    <= '0;
            lg_q    <= LG_RST;
            data_q  <= 8'h00;
            opcnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            id_q    <= id_d;
            lg_q    <= lg_d;
            data_q  <= data_d;
            opcnt_q <= opcnt_d;
        end
    end

endmodule

// File: doc/squarer_rr_scheduler.md
# squarer_rr_scheduler

Round-robin scheduler that shares one combinational 4-bit squarer datapath (partial-product generation plus the reversible summation network) among `NREQ` requesters. It accepts one operand at a time over a per-requester valid/ready handshake and drives the shared datapath input. It holds that input for a programmable settle window, captures the 8-bit square, and returns it with the requester ID over a valid/ready response channel. It sits between the requester ports and the squarer core.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; legal range 2..8.
- `SETTLE`, 1: cycles the operand is held on `sq_a` before capture; legal range 1..15.
- `IDW`, `$clog2(NREQ)`: width of the ID field.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_data`  in  4*NREQ  operands; requester i uses bits [4i+3:4i].
- `req_ready`  out  NREQ  one-hot acceptance strobe.
- `sq_a`  out  4  operand driven to the squarer datapath.
- `sq_y`  in  8  square returned by the datapath.
- `sq_garbage`  in  32  datapath garbage vector; used only under the configuration macro.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  8  captured square.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `busy`  out  1  high in EXEC or RESP.
- `op_count`  out  16  completed responses; wraps from 0xFFFF to 0.
- `err`  out  1  sticky self-check error.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` bit is set, select the winner by round robin. The search starts at `last_grant+1` modulo `NREQ`.
  - Assert `req_ready[winner]` in the same cycle. This is a Mealy output and is at most one-hot.
  - Latch the winner's operand into `a_reg` and its index into `id_reg`.
  - Set `last_grant` to the winner, load `cnt` with SETTLE-1, and go to EXEC.
  - With no `req_valid` bit set, stay in IDLE.
- EXEC:
  - `sq_a = a_reg`.
  - While `cnt != 0`, decrement `cnt`.
  - When `cnt == 0`, capture `sq_y` into `rsp_data` and go to RESP.
- RESP:
  - `rsp_valid = 1`, with `rsp_data` and `rsp_id` stable.
  - On `rsp_valid && rsp_ready`, increment `op_count` and go to IDLE.
  - With `rsp_ready` low, hold the state and all outputs indefinitely.
- `req_ready` is 0 in EXEC and RESP. Requests are never accepted while a job is in flight.
- `sq_a` is 4'h0 outside EXEC, which keeps the datapath quiescent.
- A requester that deasserts `req_valid` before its grant is simply skipped.
- `req_data` is sampled only in the grant cycle. Later changes do not affect the result.
- Arithmetic: `rsp_data` = `a_reg` * `a_reg`, range 0..225, so 8 bits suffice and there is no overflow.

## Timing
- Reset values:
  - FSM state IDLE.
  - `req_ready`=0, `sq_a`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0, `op_count`=0, `err`=0.
  - `last_grant`=NREQ-1, so requester 0 has first priority.
- Latency: grant in cycle T, `sq_a` valid in cycles T+1..T+SETTLE, capture at the end of T+SETTLE, `rsp_valid` high from T+SETTLE+1.
- Throughput: the next grant can occur no earlier than the cycle after the response handshake. The minimum period is SETTLE+2 cycles per operation.
- Reset during EXEC or RESP:
  - The in-flight result is discarded without a response.
  - `op_count` is not incremented.
  - The round-robin pointer returns to its reset value.
  - A requester still holding `req_valid` is re-arbitrated on the first cycle after reset.
- `rst` has priority over every other event in the same cycle.

## Configuration
- Macro: `SQ_SELFCHECK_EN`.
- Defined:
  - At the EXEC capture cycle, compare `sq_y` against a behavioural `a_reg*a_reg`.
  - Also require `sq_garbage[31:21]` to equal 0.
  - Any mismatch sets `err`, which stays high until `rst`.
  - The captured data is still returned unchanged.
- Undefined: `err` is tied to 0, `sq_garbage` is ignored, and no comparison logic is synthesized.

## Test plan
- Single request, NREQ=4, SETTLE=1: `req_valid`=4'b0001 with operand 4'hD at cycle T. Required: `req_ready`=4'b0001 at T, `sq_a`=4'hD at T+1, `rsp_valid` at T+2 with `rsp_data`=8'hA9 and `rsp_id`=0.
- All four requesters valid with operands 1, 2, 3, F and `rsp_ready` held at 1. Required: grants in order 0,1,2,3, each SETTLE+2=3 cycles apart, with responses 0x01, 0x04, 0x09, 0xE1 and `op_count`=4.
- Fairness: requesters 0 and 2 continuously valid. Required: grant sequence 0,2,0,2 with no repeated grant while the other requester is waiting.
- Backpressure with SETTLE=3: hold `rsp_ready`=0 for 5 cycles in RESP. Required: `rsp_valid`, `rsp_data` and `rsp_id` held stable, `req_ready`=0 and `busy`=1 throughout; a single handshake then increments `op_count` by exactly 1.
- Reset mid-EXEC: assert `rst` for 1 cycle. Required: all outputs return to reset values next cycle, no response is issued, and a still-valid requester 0 is granted on the first post-reset cycle.
- With `SQ_SELFCHECK_EN` defined: stub the datapath to return 8'h00 for operand 4'h3. Required: `err`=1 from the cycle after capture, `rsp_data`=8'h00 returned, and `err` cleared only by `rst`.
